// File: rtl/frame_buffer_arbiter_pkg.sv
// fb_pkg: shared frame-buffer widths, frame size and arbiter state encoding
package fb_pkg;
  localparam int FB_ADDR_W = 19;
  localparam int FB_PIX_W = 8;
  localparam int FB_ACTIVE_PIXELS = 307200;
  typedef enum logic [1:0] {IDLE, FETCH, DONE} arb_state_t;
endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// frame_buffer_arbiter_if: write-back request channel plus single-port RAM bus
interface frame_buffer_arbiter_if import fb_pkg::*; #(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int PIX_W = FB_PIX_W
);
  logic wrValid;
  logic wrReady;
  logic [ADDR_W-1:0] wrAddr;
  logic [PIX_W-1:0] wrData;
  logic ramEn;
  logic ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [PIX_W-1:0] ramWData;
  logic [PIX_W-1:0] ramRData;
  modport master(
    input wrValid, wrAddr, wrData, ramRData,
    output wrReady, ramEn, ramWe, ramAddr, ramWData
  );
  modport slave(
    output wrValid, wrAddr, wrData, ramRData,
    input wrReady, ramEn, ramWe, ramAddr, ramWData
  );
endinterface

// File: rtl/frame_buffer_arbiter_pixel_fifo.sv
// pixel_fifo: synchronous FIFO with flush, occupancy count and zero-when-empty head
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input logic vgaClk,
  input logic rstN,
  input logic push,
  input logic pop,
  input logic flush,
  input logic [WIDTH-1:0] pushData,
  output logic [CW-1:0] count,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic doPush, doPop;
  assign doPush = push && count != CW'(DEPTH);
  assign doPop = pop && count != '0;
  assign head = count != '0 ? mem[rp] : '0;
  always_ff @(posedge vgaClk or negedge rstN) begin
    if (!rstN) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= doPush ? wp + 1'b1 : wp;
      rp <= doPop ? rp + 1'b1 : rp;
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end
  always_ff @(posedge vgaClk)
    if (doPush && !flush) mem[wp] <= pushData;
endmodule

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: display-priority frame-buffer arbiter with pixel prefetch FIFO; FB_ARB_STATS_EN adds stall/underflow counters
module frame_buffer_arbiter import fb_pkg::*; #(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int PIX_W = FB_PIX_W,
  parameter int ACTIVE_PIXELS = FB_ACTIVE_PIXELS,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER = 8
) (
  input logic vgaClk,
  input logic rstN,
  input logic frameStart,
  input logic pixReq,
  output logic [PIX_W-1:0] pixData,
  output logic underflow,
  output logic [15:0] stallCnt,
  output logic [15:0] underflowCnt,
  frame_buffer_arbiter_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ACTIVE_PIXELS - 1);
  arb_state_t state, stateNext;
  logic [ADDR_W-1:0] rdAddr;
  logic inFlight, wrGrant, rdIssue, emptyPop;
  logic [CW-1:0] count, level;
  assign level = count + CW'(inFlight);
  assign emptyPop = pixReq && count == '0 && !frameStart;
  assign bus.wrReady = state != FETCH || level >= CW'(LOW_WATER);
  // a write granted during reset would corrupt RAM, so the grant is gated by rstN
  always_comb begin
    wrGrant = rstN && bus.wrValid && bus.wrReady;
    rdIssue = state == FETCH && !frameStart && !wrGrant && level < CW'(FIFO_DEPTH);
    bus.ramEn = wrGrant || rdIssue;
    bus.ramWe = wrGrant;
    bus.ramAddr = wrGrant ? bus.wrAddr : rdAddr;
    bus.ramWData = bus.wrData;
    stateNext = frameStart ? FETCH : rdIssue && rdAddr == LAST_ADDR ? DONE : state;
  end
  always_ff @(posedge vgaClk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      rdAddr <= '0;
      inFlight <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= stateNext;
      rdAddr <= frameStart ? '0 : rdIssue ? rdAddr + 1'b1 : rdAddr;
      inFlight <= rdIssue;
      underflow <= frameStart ? 1'b0 : emptyPop ? 1'b1 : underflow;
    end
  end
  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PIX_W)) fifo (
    .vgaClk(vgaClk),
    .rstN(rstN),
    .push(inFlight && !frameStart),
    .pop(pixReq && !frameStart),
    .flush(frameStart),
    .pushData(bus.ramRData),
    .count(count),
    .head(pixData)
  );
`ifdef FB_ARB_STATS_EN
  always_ff @(posedge vgaClk or negedge rstN) begin
    if (!rstN) begin
      stallCnt <= '0;
      underflowCnt <= '0;
    end else begin
      stallCnt <= stallCnt + (bus.wrValid && !bus.wrReady && ~&stallCnt ? 16'd1 : 16'd0);
      underflowCnt <= underflowCnt + (emptyPop && ~&underflowCnt ? 16'd1 : 16'd0);
    end
  end
`else
  assign stallCnt = '0;
  assign underflowCnt = '0;
`endif
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed vector bench for frame_buffer_arbiter in a 32-pixel frame build
module tb_frame_buffer_arbiter;
  typedef struct {
    logic fs, pr, wv;
    logic en, we;
    logic [18:0] addr;
    logic rdy;
    logic [7:0] pix;
    logic uf;
  } vec_t;
  logic vgaClk = 1'b0;
  logic rstN = 1'b0;
  logic frameStart = 1'b0;
  logic pixReq = 1'b0;
  logic [7:0] pixData;
  logic underflow;
  logic [15:0] stallCnt, underflowCnt;
  int checks = 0;
  int failures = 0;
  frame_buffer_arbiter_if #(.ADDR_W(19), .PIX_W(8)) bus();
  frame_buffer_arbiter #(.ADDR_W(19), .PIX_W(8), .ACTIVE_PIXELS(32), .FIFO_DEPTH(16), .LOW_WATER(8)) dut (
    .vgaClk(vgaClk),
    .rstN(rstN),
    .frameStart(frameStart),
    .pixReq(pixReq),
    .pixData(pixData),
    .underflow(underflow),
    .stallCnt(stallCnt),
    .underflowCnt(underflowCnt),
    .bus(bus)
  );
  always #5 vgaClk = ~vgaClk;
  function automatic logic [7:0] pixOf(input int a);
    return 8'(a * 37 + 91);
  endfunction
  always @(posedge vgaClk)
    if (bus.ramEn && !bus.ramWe) bus.ramRData <= pixOf(int'(bus.ramAddr));
  function automatic vec_t mk(input logic fs, pr, wv, en, we, input logic [18:0] addr,
                              input logic rdy, input logic [7:0] pix, input logic uf);
    vec_t v;
    v = '{fs, pr, wv, en, we, addr, rdy, pix, uf};
    return v;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic fs, pr, wv, input logic [18:0] wa = 19'd50, input logic [7:0] wd = 8'hA5);
    @(posedge vgaClk);
    #1;
    frameStart = fs;
    pixReq = pr;
    bus.wrValid = wv;
    bus.wrAddr = wa;
    bus.wrData = wd;
    @(negedge vgaClk);
  endtask
  task automatic expBus(input string tag, input logic en, we, rdy, input logic [18:0] addr);
    check({tag, ".ramEn"}, 32'(bus.ramEn), 32'(en));
    check({tag, ".ramWe"}, 32'(bus.ramWe), 32'(we));
    check({tag, ".wrReady"}, 32'(bus.wrReady), 32'(rdy));
    if (en) check({tag, ".ramAddr"}, 32'(bus.ramAddr), 32'(addr));
  endtask
  initial begin
    vec_t vec[20];
    bus.wrValid = 1'b0;
    bus.wrAddr = '0;
    bus.wrData = '0;
    #2;
    check("rst.pixData", 32'(pixData), 0);
    check("rst.underflow", 32'(underflow), 0);
    expBus("rst", 1'b0, 1'b0, 1'b1, '0);
    check("rst.stallCnt", 32'(stallCnt), 0);
    check("rst.underflowCnt", 32'(underflowCnt), 0);
    @(posedge vgaClk);
    #1 rstN = 1'b1;
    vec[0] = mk(0, 0, 0, 0, 0, '0, 1, 8'd0, 0);
    vec[1] = mk(1, 0, 0, 0, 0, '0, 1, 8'd0, 0);
    for (int k = 0; k < 16; k++)
      vec[2 + k] = mk(0, 0, 0, 1, 0, 19'(k), k >= 8, k >= 2 ? pixOf(0) : 8'd0, 0);
    vec[18] = mk(0, 0, 0, 0, 0, '0, 1, pixOf(0), 0);
    vec[19] = vec[18];
    for (int i = 0; i < 20; i++) begin
      cyc(vec[i].fs, vec[i].pr, vec[i].wv);
      expBus($sformatf("fill%0d", i), vec[i].en, vec[i].we, vec[i].rdy, vec[i].addr);
      check($sformatf("fill%0d.pixData", i), 32'(pixData), 32'(vec[i].pix));
      check($sformatf("fill%0d.underflow", i), 32'(underflow), 32'(vec[i].uf));
    end
    for (int k = 0; k < 32; k++) begin
      cyc(0, 1, 0);
      check($sformatf("drain%0d.pixData", k), 32'(pixData), 32'(pixOf(k)));
      check($sformatf("drain%0d.underflow", k), 32'(underflow), 0);
      expBus($sformatf("drain%0d", k), k >= 1 && k <= 16, 1'b0, 1'b1, 19'(15 + k));
    end
    cyc(0, 1, 0);
    check("emptyPop.pixData", 32'(pixData), 0);
    check("emptyPop.underflow", 32'(underflow), 0);
    cyc(0, 0, 0);
    check("sticky.underflow", 32'(underflow), 1);
    cyc(1, 1, 0);
    check("fsCycle.underflow", 32'(underflow), 1);
    expBus("fsCycle", 1'b0, 1'b0, 1'b1, '0);
    cyc(0, 1, 0);
    check("fsClear.underflow", 32'(underflow), 0);
    expBus("refetch0", 1'b1, 1'b0, 1'b0, 19'd0);
    cyc(0, 0, 0);
    check("earlyPop.underflow", 32'(underflow), 1);
    check("earlyPop.pixData", 32'(pixData), 0);
    expBus("refetch1", 1'b1, 1'b0, 1'b0, 19'd1);
    for (int k = 2; k <= 10; k++) begin
      cyc(0, 0, 0);
      expBus($sformatf("refetch%0d", k), 1'b1, 1'b0, k >= 8, 19'(k));
      check($sformatf("refetch%0d.pixData", k), 32'(pixData), 32'(pixOf(0)));
    end
    cyc(1, 0, 0);
    expBus("flushCycle", 1'b0, 1'b0, 1'b1, '0);
    check("flushCycle.pixData", 32'(pixData), 32'(pixOf(0)));
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 0);
      expBus($sformatf("postFlush%0d", k), 1'b1, 1'b0, k >= 8, 19'(k));
      check($sformatf("postFlush%0d.pixData", k), 32'(pixData), k < 2 ? 0 : 32'(pixOf(0)));
      check($sformatf("postFlush%0d.underflow", k), 32'(underflow), 0);
    end
    cyc(0, 0, 0);
    expBus("fullAgain", 1'b0, 1'b0, 1'b1, '0);
    cyc(1, 0, 1, 19'd50, 8'hA5);
    expBus("wrOnFs", 1'b1, 1'b1, 1'b1, 19'd50);
    check("wrOnFs.ramWData", 32'(bus.ramWData), 32'h A5);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 1, 19'd50, 8'hA5);
      expBus($sformatf("stall%0d", k), 1'b1, 1'b0, 1'b0, 19'(k));
    end
    cyc(0, 0, 1, 19'd51, 8'h5A);
    expBus("wrGrant0", 1'b1, 1'b1, 1'b1, 19'd51);
    check("wrGrant0.ramWData", 32'(bus.ramWData), 32'h5A);
    cyc(0, 0, 1, 19'd52, 8'hC3);
    expBus("wrGrant1", 1'b1, 1'b1, 1'b1, 19'd52);
    check("wrGrant1.pixData", 32'(pixData), 32'(pixOf(0)));
`ifdef FB_ARB_STATS_EN
    check("stallCnt", 32'(stallCnt), 8);
    check("underflowCnt", 32'(underflowCnt), 2);
`else
    check("stallCnt", 32'(stallCnt), 0);
    check("underflowCnt", 32'(underflowCnt), 0);
`endif
    @(posedge vgaClk);
    #1;
    bus.wrAddr = 19'd53;
    #1;
    check("midWrite.ramWe", 32'(bus.ramWe), 1);
    #1 rstN = 1'b0;
    #1;
    check("rstMid.ramWe", 32'(bus.ramWe), 0);
    check("rstMid.ramEn", 32'(bus.ramEn), 0);
    check("rstMid.wrReady", 32'(bus.wrReady), 1);
    check("rstMid.pixData", 32'(pixData), 0);
    check("rstMid.stallCnt", 32'(stallCnt), 0);
    check("rstMid.underflowCnt", 32'(underflowCnt), 0);
    @(posedge vgaClk);
    #1 rstN = 1'b1;
    bus.wrValid = 1'b0;
    @(negedge vgaClk);
    expBus("idleAfterRst", 1'b0, 1'b0, 1'b1, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
